// File: rtl/pc_gen_unit_if.sv
// Bundles the PC generator's control inputs and PC/status outputs.
// Latency: none, this is wiring only.
// Backpressure: none; stall is the only hold signal and it travels on this bus.
interface pc_gen_unit_if #(
    parameter int XLEN = 32,
    parameter int NSRC = 4
);
    logic                 stall;
    logic [NSRC-1:0]      redir_valid;
    logic [NSRC*XLEN-1:0] redir_target;
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      pc_plus_inc;
    logic                 redir_taken;
    logic                 pend_valid;
    logic                 misalign;
    logic [XLEN-1:0]      fault_addr;
    logic [31:0]          redir_count;

    // The side that requests redirects and consumes the PC.
    modport master (
        output stall, redir_valid, redir_target,
        input  pc, pc_plus_inc, redir_taken, pend_valid, misalign, fault_addr, redir_count
    );

    // The PC generator itself.
    modport slave (
        input  stall, redir_valid, redir_target,
        output pc, pc_plus_inc, redir_taken, pend_valid, misalign, fault_addr, redir_count
    );
endinterface

// File: rtl/pc_gen_unit.sv
// Front-end PC register: prioritised redirects, PC+INC path, one-entry stall buffer, misalign drop.
// Latency: a redirect seen with stall=0 lands on pc next cycle; a buffered one lands one cycle after stall falls.
// Backpressure: stall holds pc; one redirect (highest priority seen) is kept while stalled, never overflows.
module pc_gen_unit #(
    parameter int              XLEN     = 32,
    parameter int              NSRC     = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              INC      = 4,
    parameter int              ALIGN    = 2
) (
    input  logic           clk,
    input  logic           rst,
    pc_gen_unit_if.slave   bus
);
    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN) - 64'd1);

    logic [XLEN-1:0] pc_r;
    logic            pend_vld;
    logic [XLEN-1:0] pend_tgt;
    logic [IDXW-1:0] pend_idx;
    logic            taken_r;
    logic            misalign_r;
    logic [XLEN-1:0] fault_r;
    logic [31:0]     count_r;

    logic            live_vld;
    logic [IDXW-1:0] live_idx;
    logic [XLEN-1:0] live_tgt;
    logic            live_bad;
    logic            live_ok;
    logic            use_live;
    logic            load;
    logic [XLEN-1:0] load_tgt;

    // Pick the lowest-index valid source; scanning downward lets lower indices overwrite higher ones.
    always_comb begin
        live_vld = 1'b0;
        live_idx = '0;
        live_tgt = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (bus.redir_valid[i]) begin
                live_vld = 1'b1;
                live_idx = IDXW'(i);
                live_tgt = bus.redir_target[i*XLEN +: XLEN];
            end
        end
    end

    // Only the selected candidate is alignment-checked; a bad one behaves as if absent.
    // use_live covers both the pc load (not stalled) and the buffer capture (stalled):
    // the live candidate wins unless a strictly higher-priority entry is already pending.
    always_comb begin
        live_bad = live_vld && (|(live_tgt & ALIGN_MASK));
        live_ok  = live_vld && !live_bad;
        use_live = live_ok && (!pend_vld || (live_idx <= pend_idx));
        load     = !bus.stall && (pend_vld || live_ok);
        load_tgt = use_live ? live_tgt : pend_tgt;
    end

    // PC, pending buffer, taken flag and redirect counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r     <= RESET_PC;
            pend_vld <= 1'b0;
            pend_tgt <= '0;
            pend_idx <= '0;
            taken_r  <= 1'b0;
            count_r  <= '0;
        end else if (!bus.stall) begin
            pend_vld <= 1'b0;
            taken_r  <= load;
            if (load) begin
                pc_r    <= load_tgt;
                count_r <= count_r + 32'd1;
            end else begin
                pc_r <= pc_r + XLEN'(INC);
            end
        end else begin
            taken_r <= 1'b0;
            if (use_live) begin
                pend_vld <= 1'b1;
                pend_tgt <= live_tgt;
                pend_idx <= live_idx;
            end
        end
    end

    // Misalign pulse and fault address, independent of stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_r <= 1'b0;
            fault_r    <= '0;
        end else begin
            misalign_r <= live_bad;
            if (live_bad) begin
                fault_r <= live_tgt;
            end
        end
    end

    assign bus.pc          = pc_r;
    assign bus.pc_plus_inc = pc_r + XLEN'(INC);
    assign bus.redir_taken = taken_r;
    assign bus.pend_valid  = pend_vld;
    assign bus.misalign    = misalign_r;
    assign bus.fault_addr  = fault_r;
    assign bus.redir_count = count_r;
endmodule

// File: doc/pc_gen_unit.md
Name: pc_gen_unit

Overview:
- Parametrised successor to the two-input next-PC select: owns the PC register itself.
- Selects among NSRC prioritised redirect sources and the sequential PC+INC path.
- Holds the PC on stall and buffers one redirect that arrives while stalled.
- Drops misaligned targets with a fault pulse and counts redirects taken.
- Sits at the front of the RISC-V core, feeding the instruction-memory address and the PC+4 value to writeback.

Parameters:
- XLEN, 32, PC and target width in bits.
- NSRC, 4, number of redirect sources. Index 0 has the highest priority (e.g. 0 trap, 1 jalr, 2 jal, 3 branch).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- INC, 4, sequential increment.
- ALIGN, 2, number of target LSBs that must be zero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC this cycle.
- redir_valid  in  NSRC  per-source redirect request, single-cycle qualifier.
- redir_target  in  NSRC*XLEN  packed targets; source i occupies bits [i*XLEN +: XLEN].
- pc  out  XLEN  current PC, registered.
- pc_plus_inc  out  XLEN  pc+INC, combinational, wraps mod 2^XLEN.
- redir_taken  out  1  registered; 1 in the cycle after a redirect loads pc.
- pend_valid  out  1  registered; a buffered redirect is pending.
- misalign  out  1  registered one-cycle pulse; a misaligned redirect was dropped.
- fault_addr  out  XLEN  registered; target of the most recent dropped misaligned redirect.
- redir_count  out  32  registered; number of redirects loaded into pc, wraps.

Behaviour:
- Reset (rst=1 at posedge), all registers load at once:
  - pc=RESET_PC
  - pend_valid=0, pending target and index=0
  - redir_taken=0, misalign=0, fault_addr=0, redir_count=0
  - Reset overrides stall and any redirect in the same cycle.
  - Reset mid-stall discards the pending redirect.
- Live candidate: lowest index i with redir_valid[i]=1. No candidate if redir_valid is all zero.
- Alignment check: the live candidate is misaligned if target[ALIGN-1:0]!=0. The check applies only to the selected candidate.
  - Misaligned candidate is dropped: misalign=1 next cycle, fault_addr<=target, pending untouched.
  - The PC then behaves as if no redirect arrived this cycle.
- Not stalled (stall=0), next pc by priority:
  1. Pending and aligned live both present: the higher priority (lower index) wins; on equal index the live one wins. The loser is discarded.
  2. Pending only: load pending target.
  3. Aligned live only: load live target.
  4. Otherwise: pc<=pc+INC.
  - In all cases pend_valid<=0.
  - redir_taken<=1 and redir_count<=redir_count+1 iff a target was loaded.
- Stalled (stall=1):
  - pc holds, redir_taken<=0, redir_count holds.
  - Aligned live with pend_valid=0: capture target and index, pend_valid<=1.
  - Aligned live with pend_valid=1: overwrite the pending entry only if live index <= pending index; otherwise drop the live one.
- Latency: a redirect presented in cycle N with stall=0 appears on pc in cycle N+1. A pending redirect appears one cycle after stall falls.
- misalign is a pulse: it clears the cycle after it is set unless another misaligned candidate arrives.
- Wrap: pc+INC and redir_count wrap silently; no flag.
- Boundaries:
  - NSRC=1 is legal.
  - All sources valid at once: index 0 only.
  - Stall held indefinitely keeps a single pending entry; there is no overflow.

Test Plan:
- Reset then free-run, stall=0, no redirects -> pc = 0x0, 0x4, 0x8, 0xC on successive cycles; redir_count=0.
- redir_valid=4'b1010, targets src1=0x100, src3=0x200 -> next pc=0x100, redir_taken=1, redir_count=1; following cycle pc=0x104, redir_taken=0.
- stall=1, then src2=0x300, then src3=0x400 (dropped), then src1=0x500 (overwrites); stall=0 -> pc held throughout; pend_valid=1; pc=0x500 one cycle after release; pend_valid=0.
- Pending src2=0x300, release cycle with live src0=0x80 -> pc=0x80. Repeat with live src3=0x90 -> pc=0x300.
- src1 target 0x102 (misaligned) with pc=0x40 -> pc=0x44, misalign pulses once, fault_addr=0x102, redir_count unchanged.
- pc=0xFFFF_FFFC, no redirect -> pc wraps to 0x0. rst=1 during stall with pend_valid=1 -> pc=RESET_PC, pend_valid=0, counters cleared.
